stopwatch_ctrl: RTL and testbench

Run/pause/clear controller for the stopwatch datapath. Turns start/stop/reset button levels into a three-state run FSM. Generates the prescaled per-second count enable that drives the seconds counter `enable` input, and a one-cycle clear pulse for the seconds and minutes counters. Also reacts to the minutes counter's end-of-range flag. Sits between the board button synchronisers and the counter chain.

---
 rtl/stopwatch_ctrl.sv | 138 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear controller for the stopwatch counter chain.
// Turns synchronised button levels into a three-state run FSM, generates the
// per-second count enable and a one-cycle clear pulse for the counters.
// Optional lap feature: define STOPWATCH_LAP_EN to add the lap/lap_hold ports.
//
// Edge detection: each button keeps a previous-sample register and an edge is
// btn & ~btn_q at the clock edge, so a held button yields a single edge.
// Edge priority: reset > min_end > stop > start (lap is independent).
module stopwatch_ctrl #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       reset,
   input  logic       min_end,
`ifdef STOPWATCH_LAP_EN
   input  logic       lap,
   output logic       lap_hold,
`endif
   output logic       running,
   output logic       count_en,
   output logic       clr,
   output logic [1:0] state
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10
   } state_t;

   state_t        state_q, state_d;
   logic          start_q, stop_q, reset_q;
   logic          start_edge, stop_edge, reset_edge;
   logic [PW-1:0] presc_q, presc_d;
   logic          clr_q, clr_d;

   assign start_edge = start & ~start_q;
   assign stop_edge  = stop  & ~stop_q;
   assign reset_edge = reset & ~reset_q;

   // State, button history, prescaler and clear pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         reset_q <= 1'b0;
         presc_q <= '0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         stop_q  <= stop;
         reset_q <= reset;
         presc_q <= presc_d;
         clr_q   <= clr_d;
      end
   end

   // Next state, clear request and prescaler update.
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      presc_d = presc_q;
      case (state_q)
         IDLE: begin
            if (reset_edge) begin
               clr_d = 1'b1;
            end else if (start_edge) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (reset_edge || min_end) begin
               state_d = IDLE;
               clr_d   = 1'b1;
            end else if (stop_edge) begin
               state_d = PAUSE;
            end
         end
         PAUSE: begin
            if (reset_edge) begin
               state_d = IDLE;
               clr_d   = 1'b1;
            end else if (start_edge) begin
               state_d = RUN;
            end
         end
         default: begin
            // Unreachable code 2'b11: recover to IDLE and clear the counters.
            state_d = IDLE;
            clr_d   = 1'b1;
         end
      endcase
      // The prescaler only advances while the current state is RUN, so a stop
      // edge on the pulse cycle still wraps it and PAUSE then holds the value.
      if (state_d == IDLE) begin
         presc_d = '0;
      end else if (state_q == RUN) begin
         presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic lap_q;
   logic lap_hold_q;

   // Lap toggles the display freeze while running; any entry to IDLE clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_q      <= 1'b0;
         lap_hold_q <= 1'b0;
      end else begin
         lap_q <= lap;
         if (state_d == IDLE) begin
            lap_hold_q <= 1'b0;
         end else if ((state_q == RUN) && lap && !lap_q) begin
            lap_hold_q <= ~lap_hold_q;
         end
      end
   end

   assign lap_hold = lap_hold_q;
`endif

   // Outputs decode registers only, so they are glitch-free.
   assign state    = state_q;
   assign running  = (state_q == RUN);
   assign count_en = (state_q == RUN) && (presc_q == PRESC_MAX);
   assign clr      = clr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, reset, min_end, lap;
   logic       running, count_en, clr;
   logic [1:0] state;
`ifdef STOPWATCH_LAP_EN
   logic       lap_hold;
`endif

   int tests = 0;
   int fails = 0;

   // Reference model: mode 0=idle 1=run 2=pause, total RUN cycles since clear.
   int m_state, m_runs;
   bit m_clr, m_lap;
   bit p_s, p_t, p_r, p_l;

   stopwatch_ctrl #(.TICK_DIV(TD)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .reset    (reset),
      .min_end  (min_end),
`ifdef STOPWATCH_LAP_EN
      .lap      (lap),
      .lap_hold (lap_hold),
`endif
      .running  (running),
      .count_en (count_en),
      .clr      (clr),
      .state    (state)
   );

   // Clock and reset
   always #5 clk = ~clk;

   task automatic model_reset();
      m_state = 0; m_runs = 0; m_clr = 0; m_lap = 0;
      p_s = 0; p_t = 0; p_r = 0; p_l = 0;
   endtask

   task automatic model_step(input bit s, input bit t, input bit r, input bit m, input bit l);
      bit se, te, re, le;
      se = s && !p_s; te = t && !p_t; re = r && !p_r; le = l && !p_l;
      if (re || (m_state == 1 && m)) begin
         m_state = 0; m_clr = 1; m_runs = 0; m_lap = 0;
      end else begin
         m_clr = 0;
         if (m_state == 1) begin
            if (le) m_lap = !m_lap;
            m_runs++;
            if (te) m_state = 2;
         end else if (se) begin
            m_state = 1;
         end
      end
      p_s = s; p_t = t; p_r = r; p_l = l;
   endtask

   function automatic logic [4:0] exp_vec();
      return {2'(m_state), (m_state == 1), (m_state == 1) && ((m_runs % TD) == TD - 1), m_clr};
   endfunction

   // Driver: apply levels, take one clock edge, advance the model, settle.
   task automatic cycle(input bit s, input bit t, input bit r, input bit m, input bit l);
      start = s; stop = t; reset = r; min_end = m; lap = l;
      @(posedge clk);
      model_step(s, t, r, m, l);
      #1;
   endtask

   task automatic go_idle();
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst_n = 0; start = 0; stop = 0; reset = 0; min_end = 0; lap = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      model_reset();
      tests++;
      if ({state, running, count_en, clr} !== 5'b0) begin
         fails++;
         $display("FAIL reset_outputs got=%b exp=%b", {state, running, count_en, clr}, 5'b0);
      end
      cycle(0, 0, 0, 0, 0);
      tests++;
      if ({state, running, count_en, clr} !== exp_vec()) begin
         fails++;
         $display("FAIL reset_idle got=%b exp=%b", {state, running, count_en, clr}, exp_vec());
      end
   endtask

   task automatic test_start_count();
      cycle(1, 0, 0, 0, 0);
      tests++;
      if (state !== 2'b01 || running !== 1'b1 || count_en !== 1'b0 || clr !== 1'b0) begin
         fails++;
         $display("FAIL start_to_run got st=%b run=%b cen=%b clr=%b exp st=01 run=1 cen=0 clr=0",
                  state, running, count_en, clr);
      end
      for (int i = 1; i < 12; i++) begin
         cycle(0, 0, 0, 0, 0);
         tests++;
         if (count_en !== ((i % TD) == TD - 1) || clr !== 1'b0) begin
            fails++;
            $display("FAIL count_period i=%0d got cen=%b clr=%b exp cen=%b clr=0",
                     i, count_en, clr, ((i % TD) == TD - 1));
         end
      end
   endtask

   task automatic test_pause_resume();
      go_idle();
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (state !== 2'b10 || running !== 1'b0 || count_en !== 1'b0) begin
            fails++;
            $display("FAIL pause_hold i=%0d got st=%b run=%b cen=%b exp st=10 run=0 cen=0",
                     i, state, running, count_en);
         end
         cycle(0, 1, 0, 0, 0);
      end
      cycle(1, 0, 0, 0, 0);
      tests++;
      if (state !== 2'b01 || count_en !== 1'b0) begin
         fails++;
         $display("FAIL resume_first got st=%b cen=%b exp st=01 cen=0", state, count_en);
      end
      cycle(0, 0, 0, 0, 0);
      tests++;
      if (count_en !== 1'b1) begin
         fails++;
         $display("FAIL resume_pulse got cen=%b exp cen=1", count_en);
      end
      cycle(0, 0, 0, 0, 0);
      tests++;
      if (count_en !== 1'b0) begin
         fails++;
         $display("FAIL resume_after got cen=%b exp cen=0", count_en);
      end
   endtask

   task automatic test_coincident_edges();
      go_idle();
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(1, 1, 1, 0, 0);
      tests++;
      if ({state, running, count_en, clr} !== 5'b00001) begin
         fails++;
         $display("FAIL coincide_clr got=%b exp=%b", {state, running, count_en, clr}, 5'b00001);
      end
      cycle(1, 1, 1, 0, 0);
      tests++;
      if ({state, running, count_en, clr} !== 5'b00000) begin
         fails++;
         $display("FAIL coincide_one_cycle got=%b exp=%b", {state, running, count_en, clr}, 5'b00000);
      end
      cycle(0, 0, 0, 0, 0);
   endtask

   task automatic test_min_end();
      go_idle();
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0);
      tests++;
      if (state !== 2'b00 || clr !== 1'b1) begin
         fails++;
         $display("FAIL min_end_run got st=%b clr=%b exp st=00 clr=1", state, clr);
      end
      cycle(0, 0, 0, 1, 0);
      tests++;
      if (state !== 2'b00 || clr !== 1'b0) begin
         fails++;
         $display("FAIL min_end_after got st=%b clr=%b exp st=00 clr=0", state, clr);
      end
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 1, 0);
         tests++;
         if (state !== 2'b10 || clr !== 1'b0) begin
            fails++;
            $display("FAIL min_end_pause i=%0d got st=%b clr=%b exp st=10 clr=0", i, state, clr);
         end
      end
      cycle(0, 0, 0, 0, 0);
   endtask

   task automatic test_hold_and_async_reset();
      int changes;
      logic [1:0] prev;
      go_idle();
      changes = 0;
      prev = state;
      for (int i = 0; i < 20; i++) begin
         cycle(1, 0, 0, 0, 0);
         if (state !== prev) changes++;
         prev = state;
      end
      tests++;
      if (changes != 1 || state !== 2'b01) begin
         fails++;
         $display("FAIL start_held got changes=%0d st=%b exp changes=1 st=01", changes, state);
      end
      cycle(0, 0, 0, 0, 0);
      #2 rst_n = 0;
      #1;
      tests++;
      if ({state, running, count_en, clr} !== 5'b0) begin
         fails++;
         $display("FAIL async_reset got=%b exp=%b", {state, running, count_en, clr}, 5'b0);
      end
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if ({state, running, count_en, clr} !== 5'b0) begin
         fails++;
         $display("FAIL async_reset_hold got=%b exp=%b", {state, running, count_en, clr}, 5'b0);
      end
      rst_n = 1;
      model_reset();
      cycle(0, 0, 0, 0, 0);
      tests++;
      if ({state, running, count_en, clr} !== 5'b0) begin
         fails++;
         $display("FAIL async_reset_release got=%b exp=%b", {state, running, count_en, clr}, 5'b0);
      end
   endtask

`ifdef STOPWATCH_LAP_EN
   task automatic test_lap();
      go_idle();
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      tests++;
      if (lap_hold !== 1'b1) begin
         fails++;
         $display("FAIL lap_set got=%b exp=1", lap_hold);
      end
      for (int i = 0; i < 6; i++) begin
         cycle(0, 0, 0, 0, 1);
         tests++;
         if (count_en !== exp_vec()[1] || lap_hold !== 1'b1) begin
            fails++;
            $display("FAIL lap_counting i=%0d got cen=%b hold=%b exp cen=%b hold=1",
                     i, count_en, lap_hold, exp_vec()[1]);
         end
      end
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      tests++;
      if (lap_hold !== 1'b0) begin
         fails++;
         $display("FAIL lap_clear got=%b exp=0", lap_hold);
      end
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 1, 0, 0);
      tests++;
      if (lap_hold !== 1'b0 || clr !== 1'b1) begin
         fails++;
         $display("FAIL lap_reset got hold=%b clr=%b exp hold=0 clr=1", lap_hold, clr);
      end
      cycle(0, 0, 0, 0, 0);
   endtask
`endif

   task automatic test_random();
      bit s, t, r, m, l;
      for (int i = 0; i < 600; i++) begin
         s = ($urandom_range(0, 3) == 0);
         t = ($urandom_range(0, 5) == 0);
         r = ($urandom_range(0, 15) == 0);
         m = ($urandom_range(0, 19) == 0);
         l = ($urandom_range(0, 3) == 0);
         cycle(s, t, r, m, l);
         tests++;
         if ({state, running, count_en, clr} !== exp_vec() || (clr && count_en)) begin
            fails++;
            $display("FAIL random i=%0d got=%b exp=%b", i, {state, running, count_en, clr}, exp_vec());
         end
`ifdef STOPWATCH_LAP_EN
         tests++;
         if (lap_hold !== m_lap) begin
            fails++;
            $display("FAIL random_lap i=%0d got=%b exp=%b", i, lap_hold, m_lap);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_start_count();
      test_pause_resume();
      test_coincident_edges();
      test_min_end();
      test_hold_and_async_reset();
`ifdef STOPWATCH_LAP_EN
      test_lap();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
